input_or0_or1: RTL and testbench

Operand-source selector for the single-cycle CPU datapath. Each cycle it chooses between a WIDTH-bit data input, constant zero, or constant one, and presents the choice on a registered output. It sits in front of ALU/adder operands where an instruction needs its register value, a cleared operand, or an increment of one.

---
 rtl/input_or0_or1_pkg.sv | 13 +
 rtl/input_or0_or1_if.sv | 34 +++
 rtl/input_or0_or1_mux.sv | 23 ++
 rtl/input_or0_or1.sv | 61 ++++++
 tb/tb_input_or0_or1.sv | 133 +++++++++++++
 5 files changed

// File: rtl/input_or0_or1_pkg.sv
// Shared encodings and default width for the input_or0_or1 operand-source selector.
package input_or0_or1_pkg;

  localparam int DEFAULT_WIDTH = 17;

  typedef enum logic [1:0] {
    SEL_INPUT = 2'd0,
    SEL_ZERO  = 2'd1,
    SEL_ONE   = 2'd2,
    SEL_RSVD  = 2'd3
  } sel_e;

endpackage

// File: rtl/input_or0_or1_if.sv
// Operand selector bus: data in, select, registered data out.
// The sticky illegal_sel flag exists only with INPUT_OR0_OR1_ILLEGAL_SEL_FLAG_EN.
interface input_or0_or1_if
  import input_or0_or1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] Input;
  logic [1:0]       Selection;
  logic [WIDTH-1:0] Output;
`ifdef INPUT_OR0_OR1_ILLEGAL_SEL_FLAG_EN
  logic             illegal_sel;
`endif

  modport master (
    output Input,
    output Selection,
`ifdef INPUT_OR0_OR1_ILLEGAL_SEL_FLAG_EN
    input  illegal_sel,
`endif
    input  Output
  );

  modport slave (
    input  Input,
    input  Selection,
`ifdef INPUT_OR0_OR1_ILLEGAL_SEL_FLAG_EN
    output illegal_sel,
`endif
    output Output
  );

endinterface

// File: rtl/input_or0_or1_mux.sv
// Combinational next-value select: Input, zero, one, or zero for the reserved code.
module input_or0_or1_mux
  import input_or0_or1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] dout_o
);

  // Source select; reserved and unknown codes fall to the zero default
  always_comb begin
    dout_o = {WIDTH{1'b0}};
    case (sel_i)
      SEL_INPUT: dout_o = din_i;
      SEL_ZERO:  dout_o = {WIDTH{1'b0}};
      SEL_ONE:   dout_o = {{(WIDTH-1){1'b0}}, 1'b1};
      default:   dout_o = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/input_or0_or1.sv
// Registered operand-source selector. Optional sticky reserved-select flag
// enabled by defining INPUT_OR0_OR1_ILLEGAL_SEL_FLAG_EN.
module input_or0_or1
  import input_or0_or1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            reset,
  input_or0_or1_if.slave bus
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  input_or0_or1_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .din_i  (bus.Input),
    .sel_i  (bus.Selection),
    .dout_o (out_d)
  );

  // Output register; reset wins over any select value
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= {WIDTH{1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.Output = out_q;

`ifdef INPUT_OR0_OR1_ILLEGAL_SEL_FLAG_EN
  logic illegal_d;
  logic illegal_q;

  // Flag accumulates any reserved select seen outside reset
  always_comb begin
    illegal_d = illegal_q;
    if (bus.Selection == SEL_RSVD) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Sticky flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal_sel = illegal_q;
`endif

endmodule

// File: tb/tb_input_or0_or1.sv
// Self-checking bench for input_or0_or1: vector table plus scoreboard queue,
// with a randomized hold sequence.
module tb_input_or0_or1;

  localparam int W = 17;

  typedef struct {
    string      name;
    logic       rst;
    logic [W-1:0] din;
    logic [1:0] sel;
    logic [W-1:0] exp_out;
    logic       exp_flag;
  } vec_t;

  logic clk;
  logic reset;

  input_or0_or1_if #(.WIDTH(W)) bus ();

  input_or0_or1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string name, logic rst, logic [W-1:0] din,
                              logic [1:0] sel, logic [W-1:0] exp_out, logic exp_flag);
    vec_t v;
    v.name = name; v.rst = rst; v.din = din; v.sel = sel;
    v.exp_out = exp_out; v.exp_flag = exp_flag;
    return v;
  endfunction

  task automatic drive_and_check(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset         = v.rst;
    bus.Input     = v.din;
    bus.Selection = v.sel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      n_total++;
      if (bus.Output === e.exp_out) n_pass++;
      else $display("FAIL %s out got %h expected %h", e.name, bus.Output, e.exp_out);
`ifdef INPUT_OR0_OR1_ILLEGAL_SEL_FLAG_EN
      n_total++;
      if (bus.illegal_sel === e.exp_flag) n_pass++;
      else $display("FAIL %s flag got %b expected %b", e.name, bus.illegal_sel, e.exp_flag);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r;
    logic [1:0]   s;
    logic [W-1:0] e;

    reset         = 1'b1;
    bus.Input     = 17'h1FFFF;
    bus.Selection = 2'd0;

    vecs.push_back(mk("rst0",      1'b1, 17'h1FFFF, 2'd0, 17'h00000, 1'b0));
    vecs.push_back(mk("rst1",      1'b1, 17'h1FFFF, 2'd0, 17'h00000, 1'b0));
    vecs.push_back(mk("rst2",      1'b1, 17'h1FFFF, 2'd0, 17'h00000, 1'b0));
    vecs.push_back(mk("post_rst",  1'b0, 17'h1FFFF, 2'd0, 17'h1FFFF, 1'b0));
    vecs.push_back(mk("pass5",     1'b0, 17'h00005, 2'd0, 17'h00005, 1'b0));
    vecs.push_back(mk("pass_msb",  1'b0, 17'h10000, 2'd0, 17'h10000, 1'b0));
    vecs.push_back(mk("zero5",     1'b0, 17'h00005, 2'd1, 17'h00000, 1'b0));
    vecs.push_back(mk("zero_ff",   1'b0, 17'h1FFFF, 2'd1, 17'h00000, 1'b0));
    vecs.push_back(mk("zero_aa",   1'b0, 17'h0AAAA, 2'd1, 17'h00000, 1'b0));
    vecs.push_back(mk("zero_55",   1'b0, 17'h15555, 2'd1, 17'h00000, 1'b0));
    vecs.push_back(mk("one5",      1'b0, 17'h00005, 2'd2, 17'h00001, 1'b0));
    vecs.push_back(mk("one_ff",    1'b0, 17'h1FFFF, 2'd2, 17'h00001, 1'b0));
    vecs.push_back(mk("one_00",    1'b0, 17'h00000, 2'd2, 17'h00001, 1'b0));
    vecs.push_back(mk("b2b_0",     1'b0, 17'h00005, 2'd0, 17'h00005, 1'b0));
    vecs.push_back(mk("b2b_1",     1'b0, 17'h00005, 2'd1, 17'h00000, 1'b0));
    vecs.push_back(mk("b2b_2",     1'b0, 17'h00005, 2'd2, 17'h00001, 1'b0));
    vecs.push_back(mk("b2b_3",     1'b0, 17'h00005, 2'd0, 17'h00005, 1'b0));
    vecs.push_back(mk("midrst_0",  1'b0, 17'h00005, 2'd0, 17'h00005, 1'b0));
    vecs.push_back(mk("midrst_r",  1'b1, 17'h00005, 2'd2, 17'h00000, 1'b0));
    vecs.push_back(mk("midrst_2",  1'b0, 17'h00005, 2'd2, 17'h00001, 1'b0));
    vecs.push_back(mk("midrst_3",  1'b0, 17'h00005, 2'd0, 17'h00005, 1'b0));
    vecs.push_back(mk("rsvd",      1'b0, 17'h00005, 2'd3, 17'h00000, 1'b1));
    vecs.push_back(mk("rsvd_back", 1'b0, 17'h00005, 2'd0, 17'h00005, 1'b1));
    vecs.push_back(mk("rsvd_hold", 1'b0, 17'h1FFFF, 2'd1, 17'h00000, 1'b1));
    vecs.push_back(mk("rsvd_rst",  1'b1, 17'h1FFFF, 2'd3, 17'h00000, 1'b0));
    vecs.push_back(mk("after_rst", 1'b0, 17'h00005, 2'd0, 17'h00005, 1'b0));
    vecs.push_back(mk("rsvd2",     1'b0, 17'h12345, 2'd3, 17'h00000, 1'b1));
    vecs.push_back(mk("clr_rst",   1'b1, 17'h12345, 2'd0, 17'h00000, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_and_check(vecs[i]);
    end

    // Random inputs with random legal selects; flag stays clear after the last reset
    for (int k = 0; k < 12; k++) begin
      r = W'($urandom);
      s = 2'($urandom_range(0, 2));
      case (s)
        2'd0:    e = r;
        2'd2:    e = 17'h00001;
        default: e = 17'h00000;
      endcase
      drive_and_check(mk("rand", 1'b0, r, s, e, 1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
